edge_detect_multi: RTL

//   Multi-channel, parametrised edge detector. It synchronises NUM_CH asynchronous inputs
//   and glitch-filters each one. Each channel then produces a one-cycle pulse on a rising

---
 rtl/edge_detect_multi.sv | 55 +++++
 1 files changed

// File: rtl/edge_detect_multi.sv
// edge_detect_multi: per-channel synchroniser, glitch filter and rise/fall pulse detector
// feeding sticky pending flags that are ORed into a single interrupt.
module edge_detect_multi #(
  parameter int   NUM_CH      = 8,
  parameter int   SYNC_STAGES = 2,
  parameter int   FILT_CYCLES = 3,
  parameter logic RESET_LEVEL = 1'b1
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic [NUM_CH-1:0]     data_i,
  input  logic [2*NUM_CH-1:0]   mode_i,
  input  logic [NUM_CH-1:0]     clear_i,
  output logic [NUM_CH-1:0]     level_o,
  output logic [NUM_CH-1:0]     edge_pulse_o,
  output logic [NUM_CH-1:0]     edge_pending_o,
  output logic                  irq_o
);
  localparam int CW = $clog2(FILT_CYCLES + 1);
  logic [NUM_CH-1:0] level_q, level_d, pulse_q, pulse_d, pending_q, pending_d, upd;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   sy;
    assign sy         = sync_q[SYNC_STAGES-1];
    // level flips only after FILT_CYCLES consecutive samples disagreeing with it
    assign upd[c]     = (sy != level_q[c]) && (cnt_q == CW'(FILT_CYCLES - 1));
    assign cnt_d      = (sy == level_q[c] || upd[c]) ? '0 : cnt_q + 1'b1;
    assign pulse_d[c] = upd[c] && (sy ? mode_i[2*c] : mode_i[2*c+1]);
    always_ff @(posedge clk or negedge n_rst)
      if (!n_rst) begin
        sync_q <= {SYNC_STAGES{RESET_LEVEL}};
        cnt_q  <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], data_i[c]};
        cnt_q  <= cnt_d;
      end
  end
  assign level_d   = level_q ^ upd;
  assign pending_d = (pending_q & ~clear_i) | pulse_d;
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      level_q   <= {NUM_CH{RESET_LEVEL}};
      pulse_q   <= '0;
      pending_q <= '0;
    end else begin
      level_q   <= level_d;
      pulse_q   <= pulse_d;
      pending_q <= pending_d;
    end
  assign level_o        = level_q;
  assign edge_pulse_o   = pulse_q;
  assign edge_pending_o = pending_q;
  assign irq_o          = |pending_q;
endmodule
